psk_window_sched: RTL
=====================

// Module: psk_window_sched
// PURPOSE
//  Window scheduler and symbol arbiter for the PSK correlator bank.
//  - Defines correlation windows and pulses the bank clear at each window end.
//  - Captures the bank's sticky match mask and decodes it to a phase index.
//  - Tracks acquisition/lock and delivers symbols over a valid/ready interface.
//  - Sits between the correlator dispatcher datapath and downstream symbol consumers.
// PARAMETERS
//  NPHASE    6   correlator phases (width of match mask)
//  PH_W      3   phase index width, >= clog2(NPHASE)
//  WINDOW    48  clk cycles per correlation window (>=4)
//  LOCK_CNT  4   consecutive good windows to enter LOCK
//  MISS_MAX  3   consecutive erasure windows to drop LOCK
//  SLIP_AFT  8   erasure windows in ACQ before a code slip (DSP_SCHED_SLIP_EN only)
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous reset, active-high
//  en         in   1        run enable; low freezes window counter, no clears issued
//  match_mask in   NPHASE   sticky OR of correlator matches for current window
//  corr_clr   out  1        one-cycle clear to correlator bank at window end
//  code_slip  out  1        one-cycle request to rotate reference code by one chip
//  sym_data   out  PH_W+1   {ambiguous, phase index}
//  sym_valid  out  1        symbol available
//  sym_ready  in   1        consumer accepts symbol when valid&ready
//  locked     out  1        high in LOCK state
//  overflow   out  1        sticky: symbol dropped because buffer full
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, window counter 0, buffer empty, miss/good counters 0.
//  Window: counter wcnt runs 0..WINDOW-1 while en=1; at wcnt==WINDOW-1 (window end)
//   corr_clr=1 for that cycle, match_mask sampled same edge, wcnt wraps to 0.
//   en low: wcnt holds, corr_clr 0; en rising resumes from held wcnt.
//  Decode of sampled mask: 0 -> erasure; one-hot -> good, phase=bit index, amb=0;
//   multi-bit -> good, phase=lowest set index, amb=1.
//  FSM:
//   IDLE: first cycle with en=1 -> ACQ (wcnt starts that cycle).
//   ACQ: good one-hot window -> good_cnt++; erasure or ambiguous -> good_cnt=0;
//    good_cnt reaching LOCK_CNT -> LOCK (miss_cnt=0). No symbols emitted in ACQ.
//   LOCK: every window end pushes one symbol (erasures not pushed); erasure -> miss_cnt++,
//    good -> miss_cnt=0; miss_cnt reaching MISS_MAX -> ACQ, good_cnt=0.
//   Any state: rst -> IDLE next edge; en=0 does not change state.
//  Output buffer: 2-entry FIFO; push and pop same cycle allowed when non-empty.
//   sym_valid = not empty; sym_data = head; latency window-end edge -> sym_valid 1 cycle.
//   Push when full and no pop: symbol dropped, overflow set until rst.
//  locked asserted the cycle after LOCK entry; deasserted the cycle after LOCK exit.
//  Reset mid-window: buffer flushed, partial window discarded, corr_clr not issued.
// CONFIGURATION
//  DSP_SCHED_SLIP_EN defined: in ACQ, after SLIP_AFT consecutive erasure windows,
//   code_slip pulses for one cycle coincident with corr_clr; erasure count restarts.
//  Not defined: code_slip tied 0, SLIP_AFT unused.
// STRUCTURE
//  Shared package dsp_psk_pkg: state enum {IDLE,ACQ,LOCK}, NPHASE/PH_W defaults,
//   sym_t (amb + phase) typedef.
//  One sub-module: psk_sym_fifo (2-entry valid/ready FIFO with overflow flag).
//  Mask decoder (lowest-set priority encoder + popcount>1) kept inline.
// TESTING
//  1 rst, en=1, mask=0 always -> corr_clr every 48 cycles, locked=0, sym_valid=0.
//  2 mask=6'b000100 for 4 windows -> locked=1 after 4th window end, no symbols during ACQ;
//    5th window -> sym_data=4'b0010, sym_valid=1.
//  3 in LOCK, mask=6'b010010 -> sym_data=4'b1001 (amb=1, phase 1).
//  4 in LOCK, 3 windows mask=0 -> no pushes, locked drops after 3rd window end.
//  5 in LOCK, sym_ready=0 for 3 windows -> 2 symbols held, overflow=1 after 3rd.
//  6 SLIP_EN build: ACQ, mask=0 for 8 windows -> code_slip pulse with 8th corr_clr;
//    non-SLIP build -> code_slip stays 0.

Source files
------------

// File: rtl/dsp_psk_pkg.sv
// Shared types for the PSK correlator scheduler: FSM states, phase defaults, symbol layout.
package dsp_psk_pkg;

    localparam int NPHASE_DEF = 6;
    localparam int PH_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    typedef struct packed {
        logic                amb;
        logic [PH_W_DEF-1:0] phase;
    } sym_t;

endpackage

// File: rtl/psk_sym_fifo.sv
// Two-entry symbol FIFO; push-to-valid latency 1 cycle; pop on valid&ready, push and pop
// may coincide when non-empty; a push into a full FIFO without a pop is dropped and sets sticky overflow.
module psk_sym_fifo #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    output logic          pop_vld,
    output logic [DW-1:0] pop_dat,
    input  logic          pop_rdy,
    output logic          overflow
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          pop;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        pop    = (cnt_q != 2'd0) && pop_rdy;
        case (cnt_q)
            2'd0: begin
                if (push_vld) begin
                    head_d = push_dat;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push_vld && pop) begin
                    head_d = push_dat;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end else if (push_vld) begin
                    tail_d = push_dat;
                    cnt_d  = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push_vld) begin
                        tail_d = push_dat;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end else if (push_vld) begin
                    ovf_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pop_vld  = (cnt_q != 2'd0);
    assign pop_dat  = head_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/psk_window_sched.sv
// Correlation window scheduler / symbol arbiter; window-end edge -> sym_valid 1 cycle later;
// symbols wait in a 2-deep FIFO on sym_ready, excess dropped (sticky overflow). DSP_SCHED_SLIP_EN enables code slip.
module psk_window_sched
    import dsp_psk_pkg::*;
#(
    parameter int NPHASE   = NPHASE_DEF,
    parameter int PH_W     = PH_W_DEF,
    parameter int WINDOW   = 48,
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 3,
    parameter int SLIP_AFT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NPHASE-1:0] match_mask,
    output logic              corr_clr,
    output logic              code_slip,
    output logic [PH_W:0]     sym_data,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic              locked,
    output logic              overflow
);

    localparam int WC_W = $clog2(WINDOW);
    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int MC_W = $clog2(MISS_MAX + 1);

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
    logic [MC_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic             win_end;
    logic             push;
    logic [PH_W-1:0]  dec_phase;
    logic             dec_era;
    logic             dec_amb;

    // Lowest set bit wins; more than one set bit flags the symbol as ambiguous.
    always_comb begin
        dec_phase = '0;
        for (int i = NPHASE - 1; i >= 0; i--) begin
            if (match_mask[i]) dec_phase = PH_W'(i);
        end
    end

    assign dec_era = (match_mask == '0);
    assign dec_amb = |(match_mask & (match_mask - NPHASE'(1)));

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        push       = 1'b0;
        win_end    = en && !rst && (wcnt_q == WC_W'(WINDOW - 1));
        if (en) begin
            wcnt_d = win_end ? '0 : wcnt_q + WC_W'(1);
            case (state_q)
                IDLE: state_d = ACQ;
                ACQ: begin
                    if (win_end) begin
                        if (!dec_era && !dec_amb) begin
                            if (good_cnt_q == GC_W'(LOCK_CNT - 1)) begin
                                state_d    = LOCK;
                                good_cnt_d = '0;
                                miss_cnt_d = '0;
                            end else begin
                                good_cnt_d = good_cnt_q + GC_W'(1);
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                end
                LOCK: begin
                    if (win_end) begin
                        if (dec_era) begin
                            if (miss_cnt_q == MC_W'(MISS_MAX - 1)) begin
                                state_d    = ACQ;
                                good_cnt_d = '0;
                                miss_cnt_d = '0;
                            end else begin
                                miss_cnt_d = miss_cnt_q + MC_W'(1);
                            end
                        end else begin
                            push       = 1'b1;
                            miss_cnt_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

`ifdef DSP_SCHED_SLIP_EN
    localparam int EC_W = $clog2(SLIP_AFT + 1);

    logic [EC_W-1:0] era_cnt_q, era_cnt_d;
    logic            slip;

    // Counts consecutive erasure windows while acquiring; slip fires on the SLIP_AFT-th.
    always_comb begin
        era_cnt_d = era_cnt_q;
        slip      = 1'b0;
        if (state_q != ACQ) begin
            era_cnt_d = '0;
        end else if (win_end) begin
            if (!dec_era) begin
                era_cnt_d = '0;
            end else if (era_cnt_q == EC_W'(SLIP_AFT - 1)) begin
                slip      = 1'b1;
                era_cnt_d = '0;
            end else begin
                era_cnt_d = era_cnt_q + EC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            era_cnt_q <= '0;
        end else begin
            era_cnt_q <= era_cnt_d;
        end
    end

    assign code_slip = slip;
`else
    assign code_slip = 1'b0;
`endif

    psk_sym_fifo #(
        .DW(PH_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat ({dec_amb, dec_phase}),
        .pop_vld  (sym_valid),
        .pop_dat  (sym_data),
        .pop_rdy  (sym_ready),
        .overflow (overflow)
    );

    assign corr_clr = win_end;
    assign locked   = (state_q == LOCK);

endmodule
